// File: rtl/jtopl_pkg.sv
// Shared constants and types for the OPL slot register file.
package jtopl_pkg;

    localparam int unsigned JT_CH    = 9;
    localparam int unsigned JT_NSLOT = 2 * JT_CH;
    localparam int unsigned SLOT_W   = $clog2(JT_NSLOT);
    localparam int unsigned CH_W     = 4;

    localparam logic [7:0] REG_NTS  = 8'h08;
    localparam logic [7:0] REG_OP20 = 8'h20;
    localparam logic [7:0] REG_OP40 = 8'h40;
    localparam logic [7:0] REG_OP60 = 8'h60;
    localparam logic [7:0] REG_OP80 = 8'h80;
    localparam logic [7:0] REG_CHA0 = 8'hA0;
    localparam logic [7:0] REG_CHB0 = 8'hB0;

    // Bit o set means operator offset o has no operator behind it (6,7,E,F,16..1F).
    localparam logic [31:0] OP_HOLE_MASK = 32'hFFC0_C0C0;

    typedef enum logic [2:0] {
        K_NONE,
        K_OP20,
        K_OP40,
        K_OP60,
        K_OP80,
        K_CHA0,
        K_CHB0,
        K_NTS
    } reg_kind_e;

endpackage

// File: rtl/jtopl_reg_decode.sv
// Maps a latched OPL register index to its kind and target operator slot / channel.
module jtopl_reg_decode
    import jtopl_pkg::*;
#(
    parameter int unsigned CH = JT_CH
) (
    input  logic [7:0]        i_index,
    output logic              o_valid,
    output reg_kind_e         o_kind,
    output logic [SLOT_W-1:0] o_op_slot,
    output logic [CH_W-1:0]   o_ch
);

    logic [4:0]      w_off;
    logic [1:0]      w_grp;
    logic [2:0]      w_idx;
    logic [2:0]      w_idx_m;
    logic            w_op_hi;
    logic            w_hole;
    logic [CH_W-1:0] w_op_ch;

    assign w_off   = i_index[4:0];
    assign w_grp   = w_off[4:3];
    assign w_idx   = w_off[2:0];
    assign w_op_hi = (w_idx >= 3'd3);
    assign w_idx_m = w_op_hi ? (w_idx - 3'd3) : w_idx;
    assign w_op_ch = (CH_W'(w_grp) * CH_W'(3)) + CH_W'(w_idx_m);
    assign w_hole  = OP_HOLE_MASK[w_off];

    always_comb begin
        o_kind    = K_NONE;
        o_op_slot = '0;
        o_ch      = '0;
        if (!w_hole && (i_index[7:5] == REG_OP20[7:5] || i_index[7:5] == REG_OP40[7:5] ||
                        i_index[7:5] == REG_OP60[7:5] || i_index[7:5] == REG_OP80[7:5])) begin
            o_ch      = w_op_ch;
            o_op_slot = w_op_hi ? (SLOT_W'(w_op_ch) + SLOT_W'(CH)) : SLOT_W'(w_op_ch);
            if (i_index[7:5] == REG_OP20[7:5])      o_kind = K_OP20;
            else if (i_index[7:5] == REG_OP40[7:5]) o_kind = K_OP40;
            else if (i_index[7:5] == REG_OP60[7:5]) o_kind = K_OP60;
            else                                    o_kind = K_OP80;
        end else if (i_index[3:0] < CH_W'(CH) && i_index[7:4] == REG_CHA0[7:4]) begin
            o_kind = K_CHA0;
            o_ch   = i_index[3:0];
        end else if (i_index[3:0] < CH_W'(CH) && i_index[7:4] == REG_CHB0[7:4]) begin
            o_kind = K_CHB0;
            o_ch   = i_index[3:0];
        end else if (i_index == REG_NTS) begin
            o_kind = K_NTS;
        end
    end

    assign o_valid = (o_kind != K_NONE);

endmodule

// File: rtl/jtopl_slot_regs.sv
// OPL register file: stores CPU writes and replays them per slot with the
// stage I / II / IV alignment the envelope generator expects.
module jtopl_slot_regs
    import jtopl_pkg::*;
#(
    parameter int unsigned CH = JT_CH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        wr_n,
    input  logic        a0,
    input  logic [7:0]  din,
    output logic        zero,
    output logic [4:0]  slot,
    output logic        keyon_I,
    output logic        en_sus_I,
    output logic [3:0]  arate_I,
    output logic [3:0]  drate_I,
    output logic [3:0]  rrate_I,
    output logic [3:0]  sl_I,
    output logic [3:0]  mul_I,
    output logic [9:0]  fnum_I,
    output logic [2:0]  block_I,
    output logic        ks_II,
    output logic [3:0]  keycode_II,
    output logic [6:0]  tl_IV,
    output logic        amsen_IV
);

    localparam int unsigned NSLOT = 2 * CH;

    logic [7:0] r_index;
    logic       r_nts;
    logic [7:0] r_op20 [NSLOT];
    logic [7:0] r_op40 [NSLOT];
    logic [7:0] r_op60 [NSLOT];
    logic [7:0] r_op80 [NSLOT];
    logic [7:0] r_cha0 [CH];
    logic [7:0] r_chb0 [CH];

    logic              w_valid;
    reg_kind_e         w_kind;
    logic [SLOT_W-1:0] w_op_slot;
    logic [CH_W-1:0]   w_ch;

    jtopl_reg_decode #(.CH(CH)) u_dec (
        .i_index   (r_index),
        .o_valid   (w_valid),
        .o_kind    (w_kind),
        .o_op_slot (w_op_slot),
        .o_ch      (w_ch)
    );

    // CPU write path: index latch on a0=0, register store on a0=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
            r_nts   <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                r_op20[i] <= '0;
                r_op40[i] <= '0;
                r_op60[i] <= '0;
                r_op80[i] <= '0;
            end
            for (int i = 0; i < CH; i++) begin
                r_cha0[i] <= '0;
                r_chb0[i] <= '0;
            end
        end else if (cen && !wr_n) begin
            if (!a0) begin
                r_index <= din;
            end else if (w_valid) begin
                case (w_kind)
                    K_OP20:  r_op20[w_op_slot] <= din;
                    K_OP40:  r_op40[w_op_slot] <= din;
                    K_OP60:  r_op60[w_op_slot] <= din;
                    K_OP80:  r_op80[w_op_slot] <= din;
                    K_CHA0:  r_cha0[w_ch]      <= din;
                    K_CHB0:  r_chb0[w_ch]      <= din;
                    K_NTS:   r_nts             <= din[6];
                    default: ;
                endcase
            end
        end
    end

    logic [SLOT_W-1:0] w_slot_nxt;
    logic [CH_W-1:0]   w_rd_ch;
    logic [7:0]        w_op20, w_op40, w_op60, w_op80, w_cha0, w_chb0;
    logic [3:0]        w_keycode;
    logic              w_unused;

    assign w_slot_nxt = (slot == SLOT_W'(NSLOT - 1)) ? '0 : (slot + SLOT_W'(1));
    assign w_rd_ch    = (w_slot_nxt >= SLOT_W'(CH)) ? CH_W'(w_slot_nxt - SLOT_W'(CH))
                                                    : CH_W'(w_slot_nxt);
    assign w_op20     = r_op20[w_slot_nxt];
    assign w_op40     = r_op40[w_slot_nxt];
    assign w_op60     = r_op60[w_slot_nxt];
    assign w_op80     = r_op80[w_slot_nxt];
    assign w_cha0     = r_cha0[w_rd_ch];
    assign w_chb0     = r_chb0[w_rd_ch];
    assign w_keycode  = {w_chb0[4:2], r_nts ? w_chb0[0] : w_chb0[1]};
    // VIB, KSL and the top bits of 0xB0 are held but feed no output.
    assign w_unused   = ^{w_op20[6], w_op40[7:6], w_chb0[7:6]};

    logic       r_ks_I;
    logic [3:0] r_kc_I;
    logic [6:0] r_tl_I, r_tl_II, r_tl_III;
    logic       r_am_I, r_am_II, r_am_III;

    // Slot sequencer and readout pipeline; the lookup targets the slot being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= '0;
            zero       <= 1'b1;
            keyon_I    <= 1'b0;
            en_sus_I   <= 1'b0;
            arate_I    <= '0;
            drate_I    <= '0;
            rrate_I    <= '0;
            sl_I       <= '0;
            mul_I      <= '0;
            fnum_I     <= '0;
            block_I    <= '0;
            r_ks_I     <= 1'b0;
            r_kc_I     <= '0;
            ks_II      <= 1'b0;
            keycode_II <= '0;
            r_tl_I     <= '0;
            r_tl_II    <= '0;
            r_tl_III   <= '0;
            tl_IV      <= '0;
            r_am_I     <= 1'b0;
            r_am_II    <= 1'b0;
            r_am_III   <= 1'b0;
            amsen_IV   <= 1'b0;
        end else if (cen) begin
            slot       <= w_slot_nxt;
            zero       <= (w_slot_nxt == '0);
            keyon_I    <= w_chb0[5];
            en_sus_I   <= w_op20[5];
            mul_I      <= w_op20[3:0];
            arate_I    <= w_op60[7:4];
            drate_I    <= w_op60[3:0];
            sl_I       <= w_op80[7:4];
            rrate_I    <= w_op80[3:0];
            fnum_I     <= {w_chb0[1:0], w_cha0};
            block_I    <= w_chb0[4:2];
            r_ks_I     <= w_op20[4];
            r_kc_I     <= w_keycode;
            ks_II      <= r_ks_I;
            keycode_II <= r_kc_I;
            r_tl_I     <= {w_op40[5:0], 1'b0};
            r_tl_II    <= r_tl_I;
            r_tl_III   <= r_tl_II;
            tl_IV      <= r_tl_III;
            r_am_I     <= w_op20[7];
            r_am_II    <= r_am_I;
            r_am_III   <= r_am_II;
            amsen_IV   <= r_am_III;
        end
    end

endmodule
